fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle decode/execute core.
- Generates word-aligned fetch addresses and issues them to an instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned words, paired with their PCs, in a small FIFO and presents them to the core over a valid/ready channel.
- On a branch/jump redirect it flushes buffered and in-flight instructions and restarts fetch at the new target.

Parameters:
- WIDTH, 32, data/address width.
- DEPTH, 4, prefetch FIFO entries (power of two, >=2).
- MAX_OUTST, 2, maximum in-flight memory requests (1..DEPTH).
- RESET_PC, 32'd0, first fetch address after reset.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts request this cycle.
- mem_req_addr  output  WIDTH  word-aligned fetch address (bits [1:0] always 0).
- mem_rsp_valid  input  1  response word valid; responses return in request order.
- mem_rsp_data  input  WIDTH  instruction word.
- instr_valid  output  1  FIFO head valid toward core.
- instr_ready  input  1  core consumes head this cycle.
- instr  output  WIDTH  head instruction word.
- instr_pc  output  WIDTH  PC of head instruction.
- redirect_valid  input  1  core taken branch/JAL/JALR this cycle.
- redirect_pc  input  WIDTH  new target; bits [1:0] ignored.

Behaviour:
- State: fetch_pc, FIFO (entries of {pc, instr}, rd/wr pointers, count), outst (in-flight count, 0..MAX_OUTST), drop (stale responses still to discard), pc queue of issued addresses (MAX_OUTST deep).
- Reset values: fetch_pc = RESET_PC, FIFO empty, outst = 0, drop = 0. Outputs: mem_req_valid = 0, instr_valid = 0, instr/instr_pc = 0 while empty.
- Issue rule (combinational): mem_req_valid = !reset && !redirect_valid && outst < MAX_OUTST && (count + outst - drop) < DEPTH. Credits guarantee every accepted response has a FIFO slot. mem_req_addr = fetch_pc.
- Request handshake: on mem_req_valid && mem_req_ready, push fetch_pc to the pc queue, fetch_pc += 4 (wraps modulo 2^WIDTH), outst += 1.
- Response handling: on mem_rsp_valid, outst -= 1 and pop the pc queue.
  - If drop > 0: discard the word, drop -= 1.
  - Otherwise: push {popped pc, mem_rsp_data} into the FIFO.
- Response latency: minimum 1 cycle after acceptance. A response may arrive in the same cycle as a new request acceptance; both count updates apply.
- Decode side: instr_valid = (count != 0). instr/instr_pc are driven from the FIFO head (first-word-fall-through). Pop on instr_valid && instr_ready.
- Simultaneous push and pop: count unchanged. A push into a full FIFO cannot occur by construction; the bench asserts this.
- Redirect (highest priority), on redirect_valid in cycle N:
  - FIFO flushed (count = 0, pointers reset).
  - fetch_pc = {redirect_pc[WIDTH-1:2], 2'b00}.
  - drop = outst after this cycle's response, i.e. every still-in-flight request is stale.
  - A response arriving in cycle N is discarded.
  - No request is issued in cycle N.
  - Any pop in cycle N is still honoured by the core (the core executed it), but FIFO contents are cleared regardless.
  - instr_valid is 0 in cycle N+1.
  - Earliest new request in cycle N+1.
  - Back-to-back redirects: the last one wins; drop is recomputed each time.
- Latency: with mem_req_ready = 1 and 1-cycle memory, first instr_valid occurs 2 cycles after reset deassertion (request in cycle 0, response in cycle 1, FIFO visible in cycle 2). Sustained throughput is 1 instr/cycle.
- Reset mid-operation clears all state. The instruction memory shares the reset and discards pending requests; responses in the reset cycle are ignored.
- No speculation beyond sequential +4 prediction. No compressed instructions.

Test Plan:
- Reset release, RESET_PC = 0, 1-cycle memory returning addr>>2, instr_ready = 1 -> instr_pc sequence 0,4,8,12 on consecutive cycles; first instr_valid 2 cycles after reset deasserts; instr = 0,1,2,3.
- instr_ready held 0 for 20 cycles -> exactly DEPTH = 4 words buffered; mem_req_valid stays 0 once count + outst = 4; on instr_ready = 1, PCs 0..12 emerge in order with no loss.
- 3-cycle memory latency with two requests outstanding, redirect_pc = 0x103 asserted -> both stale responses dropped; next instr_pc = 0x100; first post-redirect mem_req_addr = 0x100 in cycle N+1.
- Redirect in the same cycle a response arrives and instr_ready = 1 -> that response discarded; instr_valid = 0 next cycle; no request issued in cycle N.
- mem_req_ready toggled randomly for 1000 cycles with random redirects -> every delivered instr_pc matches a scoreboard of sequential/redirected PCs; no FIFO overflow.
- reset asserted with FIFO full and outst = 2 -> next cycle instr_valid = 0, mem_req_addr = RESET_PC, outst = 0, drop = 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential +4 prefetch into a small FWFT FIFO of
// {pc, instr} pairs, with redirect flush and discard of stale in-flight responses.
module fetch_unit #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter int               MAX_OUTST = 2,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clock,
  input  logic             reset,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rsp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [OW-1:0]    outst_q, outst_d, drop_q, drop_d;
  logic [QW-1:0]    pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;

  logic [WIDTH-1:0] fifo_pc_q    [DEPTH];
  logic [WIDTH-1:0] fifo_instr_q [DEPTH];
  logic [WIDTH-1:0] pcq_q        [MAX_OUTST];

  logic [OW-1:0] live_outst;
  logic [CW:0]   credits_used;
  logic          req_fire, rsp_fire, push, pop;
  logic [1:0]    unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Slots already promised: buffered words plus responses that will be kept.
  assign live_outst   = outst_q - drop_q;
  assign credits_used = (CW+1)'(count_q) + (CW+1)'(live_outst);

  assign mem_req_valid = !reset && !redirect_valid
                         && (outst_q < OW'(MAX_OUTST))
                         && (credits_used < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]    : '0;

  assign req_fire = mem_req_valid && mem_req_ready;
  assign rsp_fire = mem_rsp_valid && (outst_q != '0);
  assign push     = rsp_fire && (drop_q == '0) && !redirect_valid;
  assign pop      = instr_valid && instr_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    outst_d    = outst_q + OW'(req_fire) - OW'(rsp_fire);
    drop_d     = drop_q;
    pcq_rd_d   = pcq_rd_q;
    pcq_wr_d   = pcq_wr_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + WIDTH'(32'd4);
      pcq_wr_d   = (pcq_wr_q == QW'(MAX_OUTST - 1)) ? '0 : pcq_wr_q + QW'(1);
    end
    if (rsp_fire) begin
      pcq_rd_d = (pcq_rd_q == QW'(MAX_OUTST - 1)) ? '0 : pcq_rd_q + QW'(1);
      if (drop_q != '0) drop_d = drop_q - OW'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    // No request fires during a redirect, so outst_d is exactly what is left in flight.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_d     = outst_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= {RESET_PC[WIDTH-1:2], 2'b00};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_wr_q   <= pcq_wr_d;
    end
  end

  // Storage needs no reset: validity is tracked entirely by pointers and counts.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clock) begin
        if (push && (wr_ptr_q == AW'(gi))) begin
          fifo_pc_q[gi]    <= pcq_q[pcq_rd_q];
          fifo_instr_q[gi] <= mem_rsp_data;
        end
      end
    end
    for (gi = 0; gi < MAX_OUTST; gi++) begin : g_pcq
      always_ff @(posedge clock) begin
        if (req_fire && (pcq_wr_q == QW'(gi))) begin
          pcq_q[gi] <= fetch_pc_q;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random-redirect bench for fetch_unit with an in-order
// variable-latency instruction memory that returns addr>>2.
module tb_fetch_unit;
  localparam int          W     = 32;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'd0;

  logic          clock = 1'b0;
  logic          reset, mem_req_ready, mem_rsp_valid, instr_ready, redirect_valid;
  logic [W-1:0]  mem_rsp_data, redirect_pc;
  logic          mem_req_valid, instr_valid;
  logic [W-1:0]  mem_req_addr, instr, instr_pc;

  fetch_unit #(.WIDTH(W), .DEPTH(DEPTH), .MAX_OUTST(MAXO), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial forever #5 clock = ~clock;

  int vectors = 0, miscompares = 0, cyc = 0, model_cnt = 0, s_mcnt = 0, n_issued = 0;
  int lat_min = 1, lat_max = 1;
  logic        drv_reset = 1'b1, drv_rdy = 1'b1, drv_irdy = 1'b1, drv_redir = 1'b0;
  logic [31:0] drv_redir_pc = '0;
  logic        s_req_valid, s_ivalid, s_pop;
  logic [31:0] s_req_addr, s_instr, s_ipc;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  bit          mq_stale[$];

  // One clock cycle: drive inputs, sample mid-cycle, update memory and FIFO-occupancy model.
  task automatic cycle();
    bit rsp_stale;
    reset          = drv_reset;
    mem_req_ready  = drv_rdy;
    instr_ready    = drv_irdy;
    redirect_valid = drv_redir;
    redirect_pc    = drv_redir_pc;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mq_addr[0] >> 2;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'hdead_beef;
    end
    #3;
    s_req_valid = mem_req_valid;
    s_req_addr  = mem_req_addr;
    s_ivalid    = instr_valid;
    s_instr     = instr;
    s_ipc       = instr_pc;
    s_pop       = instr_valid && instr_ready;
    s_mcnt      = model_cnt;
    rsp_stale   = 1'b0;
    if (mem_rsp_valid) begin
      rsp_stale = mq_stale[0];
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
      void'(mq_stale.pop_front());
    end
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
      mq_stale.delete();
      model_cnt = 0;
    end else begin
      if (s_pop) model_cnt--;
      if (redirect_valid) begin
        model_cnt = 0;
        foreach (mq_stale[i]) mq_stale[i] = 1'b1;
      end else if (mem_rsp_valid && !rsp_stale) begin
        model_cnt++;
      end
      if (s_req_valid && mem_req_ready) begin
        mq_addr.push_back(s_req_addr);
        mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        mq_stale.push_back(1'b0);
        n_issued++;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    drv_reset = 1'b1;
    drv_redir = 1'b0;
    repeat (2) cycle();
    drv_reset = 1'b0;
  endtask

  task automatic test_reset();
    drv_reset = 1'b1;
    cycle();
    cycle();
    vectors++; if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid got %b want 0", s_req_valid); end
    vectors++; if (s_ivalid !== 1'b0) begin miscompares++; $display("FAIL rst_instr_valid got %b want 0", s_ivalid); end
    vectors++; if (s_instr !== 32'd0) begin miscompares++; $display("FAIL rst_instr got %h want 0", s_instr); end
    vectors++; if (s_ipc !== 32'd0) begin miscompares++; $display("FAIL rst_instr_pc got %h want 0", s_ipc); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    lat_min = 1; lat_max = 1;
    do_reset();
    drv_rdy = 1'b1; drv_irdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k == 0) begin
        vectors++; if (s_req_valid !== 1'b1 || s_req_addr !== RPC) begin miscompares++; $display("FAIL seq_first_req got v=%b a=%h want v=1 a=%h", s_req_valid, s_req_addr, RPC); end
      end
      if (k < 2) begin
        vectors++; if (s_ivalid !== 1'b0) begin miscompares++; $display("FAIL seq_early_valid k=%0d got %b want 0", k, s_ivalid); end
      end else begin
        vectors++; if (s_ivalid !== 1'b1 || s_ipc !== RPC + 32'(4*(k-2)) || s_instr !== 32'(k-2))
          begin miscompares++; $display("FAIL seq_word k=%0d got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, s_ivalid, s_ipc, s_instr, RPC + 32'(4*(k-2)), 32'(k-2)); end
      end
      $display("seq cycle %0d: valid=%b pc=%h instr=%h", k, s_ivalid, s_ipc, s_instr);
    end
  endtask

  task automatic test_stall();
    int start;
    lat_min = 1; lat_max = 1;
    do_reset();
    drv_irdy = 1'b0;
    start = n_issued;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (k >= 4) begin
        vectors++; if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL stall_req_blocked k=%0d got %b want 0", k, s_req_valid); end
      end
    end
    vectors++; if (n_issued - start != DEPTH) begin miscompares++; $display("FAIL stall_issued got %0d want %0d", n_issued - start, DEPTH); end
    vectors++; if (s_ivalid !== 1'b1 || s_ipc !== RPC) begin miscompares++; $display("FAIL stall_head got v=%b pc=%h want v=1 pc=%h", s_ivalid, s_ipc, RPC); end
    drv_irdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      vectors++; if (s_ivalid !== 1'b1 || s_ipc !== RPC + 32'(4*k) || s_instr !== 32'(k))
        begin miscompares++; $display("FAIL stall_drain k=%0d got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, s_ivalid, s_ipc, s_instr, RPC + 32'(4*k), 32'(k)); end
      $display("drain %0d: pc=%h instr=%h", k, s_ipc, s_instr);
    end
  endtask

  task automatic test_redirect_inflight();
    bit found;
    lat_min = 3; lat_max = 3;
    do_reset();
    drv_irdy = 1'b1; drv_rdy = 1'b1;
    repeat (3) cycle();
    vectors++; if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL infl_outst_cap got %b want 0", s_req_valid); end
    drv_redir = 1'b1; drv_redir_pc = 32'h103;
    cycle();
    vectors++; if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL infl_req_in_redirect got %b want 0", s_req_valid); end
    drv_redir = 1'b0;
    cycle();
    vectors++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin miscompares++; $display("FAIL infl_first_req got v=%b a=%h want v=1 a=100", s_req_valid, s_req_addr); end
    vectors++; if (s_ivalid !== 1'b0) begin miscompares++; $display("FAIL infl_valid_after got %b want 0", s_ivalid); end
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      cycle();
      found = s_ivalid;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL infl_timeout got no instr_valid want one within 20 cycles"); end
    else if (s_ipc !== 32'h100 || s_instr !== 32'h40) begin miscompares++; $display("FAIL infl_first_word got pc=%h i=%h want pc=100 i=40", s_ipc, s_instr); end
    $display("redirect inflight: first pc=%h instr=%h", s_ipc, s_instr);
  endtask

  task automatic test_redirect_rsp();
    lat_min = 1; lat_max = 1;
    do_reset();
    drv_irdy = 1'b1; drv_rdy = 1'b1;
    repeat (3) cycle();
    drv_redir = 1'b1; drv_redir_pc = 32'h200;
    cycle();
    vectors++; if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL rsp_req_in_redirect got %b want 0", s_req_valid); end
    vectors++; if (s_pop !== 1'b1 || s_ipc !== 32'h4) begin miscompares++; $display("FAIL rsp_pop_honoured got pop=%b pc=%h want pop=1 pc=4", s_pop, s_ipc); end
    drv_redir = 1'b0;
    cycle();
    vectors++; if (s_ivalid !== 1'b0) begin miscompares++; $display("FAIL rsp_valid_n1 got %b want 0", s_ivalid); end
    vectors++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h200) begin miscompares++; $display("FAIL rsp_req_n1 got v=%b a=%h want v=1 a=200", s_req_valid, s_req_addr); end
    cycle();
    vectors++; if (s_ivalid !== 1'b0) begin miscompares++; $display("FAIL rsp_valid_n2 got %b want 0", s_ivalid); end
    cycle();
    vectors++; if (s_ivalid !== 1'b1 || s_ipc !== 32'h200 || s_instr !== 32'h80) begin miscompares++; $display("FAIL rsp_first_word got v=%b pc=%h i=%h want v=1 pc=200 i=80", s_ivalid, s_ipc, s_instr); end
    $display("redirect with response: first pc=%h instr=%h", s_ipc, s_instr);
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    int delivered = 0, redirects = 0;
    lat_min = 1; lat_max = 3;
    do_reset();
    exp_pc = RPC;
    for (int k = 0; k < 1000; k++) begin
      drv_rdy      = 1'($urandom_range(0, 1));
      drv_irdy     = ($urandom_range(0, 3) != 0);
      drv_redir    = ($urandom_range(0, 24) == 0);
      drv_redir_pc = $urandom;
      cycle();
      vectors++; if (s_ivalid !== (s_mcnt != 0)) begin miscompares++; $display("FAIL rnd_valid k=%0d got %b want %b", k, s_ivalid, s_mcnt != 0); end
      if (s_pop) begin
        vectors++; if (s_ipc !== exp_pc || s_instr !== (exp_pc >> 2))
          begin miscompares++; $display("FAIL rnd_word k=%0d got pc=%h i=%h want pc=%h i=%h", k, s_ipc, s_instr, exp_pc, exp_pc >> 2); end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (drv_redir) begin
        vectors++; if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_req_in_redirect k=%0d got 1 want 0", k); end
        exp_pc = {drv_redir_pc[31:2], 2'b00};
        redirects++;
      end
      if (s_req_valid) begin
        vectors++; if (s_req_addr[1:0] !== 2'b00) begin miscompares++; $display("FAIL rnd_align k=%0d got %h want low bits 0", k, s_req_addr); end
      end
      vectors++; if (model_cnt > DEPTH || model_cnt < 0 || mq_addr.size() > MAXO)
        begin miscompares++; $display("FAIL rnd_overflow k=%0d got fifo=%0d inflight=%0d want <=%0d,<=%0d", k, model_cnt, mq_addr.size(), DEPTH, MAXO); end
    end
    drv_redir = 1'b0;
    $display("random: %0d delivered, %0d redirects", delivered, redirects);
  endtask

  task automatic test_reset_midop();
    lat_min = 3; lat_max = 3;
    do_reset();
    drv_irdy = 1'b0; drv_rdy = 1'b1;
    repeat (7) cycle();
    drv_reset = 1'b1;
    cycle();
    vectors++; if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL mid_req_in_reset got %b want 0", s_req_valid); end
    drv_reset = 1'b0; drv_irdy = 1'b1;
    lat_min = 1; lat_max = 1;
    cycle();
    vectors++; if (s_ivalid !== 1'b0) begin miscompares++; $display("FAIL mid_valid_after got %b want 0", s_ivalid); end
    vectors++; if (s_req_valid !== 1'b1 || s_req_addr !== RPC) begin miscompares++; $display("FAIL mid_req0 got v=%b a=%h want v=1 a=%h", s_req_valid, s_req_addr, RPC); end
    cycle();
    vectors++; if (s_req_valid !== 1'b1 || s_req_addr !== RPC + 32'd4) begin miscompares++; $display("FAIL mid_req1 got v=%b a=%h want v=1 a=%h", s_req_valid, s_req_addr, RPC + 32'd4); end
    cycle();
    vectors++; if (s_ivalid !== 1'b1 || s_ipc !== RPC || s_instr !== 32'd0) begin miscompares++; $display("FAIL mid_first_word got v=%b pc=%h i=%h want v=1 pc=%h i=0", s_ivalid, s_ipc, s_instr, RPC); end
    $display("reset mid-op: first pc=%h instr=%h", s_ipc, s_instr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_inflight();
    test_redirect_rsp();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
